// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: reads one byte per cycle from memory,
// assembles 1- or 2-byte instructions and offers them on a valid/ready handshake.
module fetch_unit #(
  parameter int           n        = 8,
  parameter logic [n-1:0] START_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [n-1:0] mem_addr,
  input  logic [n-1:0] mem_data,
  input  logic         pc_load,
  input  logic [n-1:0] pc_target,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [n-1:0] opcode,
  output logic [n-1:0] operand,
  output logic         has_operand,
  output logic [n-1:0] instr_pc
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam logic [n-1:0] PC_INC = {{(n-1){1'b0}}, 1'b1};

  state_t       state, state_d;
  logic [n-1:0] pc, pc_d;
  logic [n-1:0] opcode_d, operand_d, instr_pc_d;
  logic         has_operand_d, instr_valid_d;

  // Address comes straight from the PC register, never from handshake inputs.
  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH_OP;
      pc          <= START_PC;
      instr_valid <= 1'b0;
      opcode      <= '0;
      operand     <= '0;
      has_operand <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr_valid <= instr_valid_d;
      opcode      <= opcode_d;
      operand     <= operand_d;
      has_operand <= has_operand_d;
      instr_pc    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instr_valid_d = instr_valid;
    opcode_d      = opcode;
    operand_d     = operand;
    has_operand_d = has_operand;
    instr_pc_d    = instr_pc;

    // A redirect discards whatever is in flight, even an instruction being accepted.
    if (pc_load) begin
      pc_d          = pc_target;
      instr_valid_d = 1'b0;
      state_d       = FETCH_OP;
    end else begin
      unique case (state)
        FETCH_OP: begin
          opcode_d      = mem_data;
          instr_pc_d    = pc;
          pc_d          = pc + PC_INC;
          has_operand_d = mem_data[n-1];
          if (mem_data[n-1]) begin
            state_d = FETCH_ARG;
          end else begin
            operand_d     = '0;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
        FETCH_ARG: begin
          operand_d     = mem_data;
          pc_d          = pc + PC_INC;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH_OP;
          end
        end
        default: begin
          instr_valid_d = 1'b0;
          state_d       = FETCH_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a byte-counting reference model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       has_operand;
  logic [7:0] instr_pc;

  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  // Reference model: PC, bytes collected for the current instruction, and the
  // instruction fields as they must be presented once complete.
  logic [7:0] m_pc;
  int         m_got;
  logic       m_valid;
  logic [7:0] m_op, m_arg, m_ipc;
  logic       m_has;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  fetch_unit #(.n(8), .START_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .has_operand (has_operand),
    .instr_pc    (instr_pc)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [7:0] b;
    if (reset) begin
      m_pc = 8'h00; m_got = 0; m_valid = 1'b0;
      m_op = 8'h00; m_arg = 8'h00; m_ipc = 8'h00; m_has = 1'b0;
    end else if (pc_load) begin
      m_pc = pc_target; m_got = 0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid = 1'b0;
        m_got   = 0;
      end
    end else begin
      b = mem[m_pc];
      if (m_got == 0) begin
        m_op = b; m_ipc = m_pc; m_has = b[7]; m_arg = 8'h00;
      end else begin
        m_arg = b;
      end
      m_got++;
      m_pc = m_pc + 8'd1;
      if (m_got == (m_has ? 2 : 1)) m_valid = 1'b1;
    end
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", 8'(instr_valid), 8'(m_valid));
    if (m_valid) begin
      chk("opcode", opcode, m_op);
      chk("operand", operand, m_arg);
      chk("has_operand", 8'(has_operand), 8'(m_has));
      chk("instr_pc", instr_pc, m_ipc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h83;
    mem[8'h02] = 8'h2A;
    mem[8'h03] = 8'h01;
    mem[8'h04] = 8'h81;
    mem[8'h40] = 8'h07;
    mem[8'hFF] = 8'h90;
    reset = 1'b1; pc_load = 1'b0; pc_target = 8'h00; instr_ready = 1'b0;
    m_pc = 8'h00; m_got = 0; m_valid = 1'b0;
    m_op = 8'h00; m_arg = 8'h00; m_ipc = 8'h00; m_has = 1'b0;

    // Reset held two cycles
    step(); step();
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_valid", 8'(instr_valid), 8'd0);
    chk("rst_opcode", opcode, 8'h00);

    // 1-byte instruction after reset release
    reset = 1'b0;
    step();
    chk("t1_valid", 8'(instr_valid), 8'd1);
    chk("t1_opcode", opcode, 8'h05);
    chk("t1_operand", operand, 8'h00);
    chk("t1_has", 8'(has_operand), 8'd0);
    chk("t1_ipc", instr_pc, 8'h00);
    instr_ready = 1'b1;
    step();
    chk("t1_accept_valid", 8'(instr_valid), 8'd0);
    chk("t1_next_addr", mem_addr, 8'h01);

    // 2-byte instruction, consumer ready
    step();
    chk("t2_arg_valid", 8'(instr_valid), 8'd0);
    step();
    chk("t2_valid", 8'(instr_valid), 8'd1);
    chk("t2_opcode", opcode, 8'h83);
    chk("t2_operand", operand, 8'h2A);
    chk("t2_has", 8'(has_operand), 8'd1);
    chk("t2_ipc", instr_pc, 8'h01);
    step();
    chk("t2_one_cycle", 8'(instr_valid), 8'd0);
    chk("t2_next_addr", mem_addr, 8'h03);

    // Backpressure in HOLD
    instr_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", 8'(instr_valid), 8'd1);
      chk("t3_hold_opcode", opcode, 8'h01);
      chk("t3_hold_addr", mem_addr, 8'h04);
    end
    instr_ready = 1'b1;
    step();
    chk("t3_release_valid", 8'(instr_valid), 8'd0);
    chk("t3_release_addr", mem_addr, 8'h04);

    // Redirect while waiting for the operand byte
    step();
    chk("t4_in_arg_addr", mem_addr, 8'h05);
    pc_load = 1'b1; pc_target = 8'h40;
    step();
    chk("t4_drop_valid", 8'(instr_valid), 8'd0);
    chk("t4_redirect_addr", mem_addr, 8'h40);
    pc_load = 1'b0;
    step();
    chk("t4_ipc", instr_pc, 8'h40);
    chk("t4_opcode", opcode, 8'h07);
    step();

    // PC wrap with the operand at address 0
    mem[8'h00] = 8'h11;
    pc_load = 1'b1; pc_target = 8'hFF;
    step();
    pc_load = 1'b0;
    step();
    chk("t5_wrap_addr", mem_addr, 8'h00);
    step();
    chk("t5_opcode", opcode, 8'h90);
    chk("t5_operand", operand, 8'h11);
    chk("t5_ipc", instr_pc, 8'hFF);
    chk("t5_next_addr", mem_addr, 8'h01);

    // Reset in HOLD, then reset together with a redirect
    instr_ready = 1'b0; reset = 1'b1;
    step();
    chk("t6_valid", 8'(instr_valid), 8'd0);
    chk("t6_pc", mem_addr, 8'h00);
    chk("t6_opcode", opcode, 8'h00);
    chk("t6_operand", operand, 8'h00);
    chk("t6_ipc", instr_pc, 8'h00);
    pc_load = 1'b1; pc_target = 8'h55;
    step();
    chk("t6_reset_wins", mem_addr, 8'h00);

    // Randomized traffic
    reset = 1'b0; pc_load = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      pc_load     = ($urandom_range(0, 15) == 0);
      pc_target   = 8'($urandom);
      instr_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) mem[8'($urandom)] = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
